// File: rtl/key_debounce_pkg.sv
// Shared definitions for the key debouncer: FSM state encoding, counter
// width and the default timing constants (also used by clk_divider's T).
package key_debounce_pkg;

  localparam int CNT_W = 30;

  // 20 ms debounce and 1 s long-press at a 50 MHz system clock.
  localparam logic [CNT_W-1:0] T_DEBOUNCE_DEF = 30'd1_000_000;
  localparam logic [CNT_W-1:0] T_LONG_DEF     = 30'd50_000_000;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_FILT = 2'd1,
    PRESSED    = 2'd2,
    REL_FILT   = 2'd3
  } state_t;

  // The key counts as held down while pressed or while a release is being filtered.
  function automatic logic is_down(input state_t s);
    return (s == PRESSED) || (s == REL_FILT);
  endfunction

endpackage

// File: rtl/key_debounce_sync_2ff.sv
// Two-flop synchroniser for asynchronous pins, with a configurable reset
// value so a pin can reset to its inactive level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so both flops
  // sample their inputs from the same edge and form a real 2-stage chain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_debounce.sv
// Push-button debouncer: synchronises the raw pin, filters both edges and
// emits press / release / long-press strobes plus a debounced level.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter logic [CNT_W-1:0] T_DEBOUNCE     = T_DEBOUNCE_DEF,
  parameter logic [CNT_W-1:0] T_LONG         = T_LONG_DEF,
  parameter logic             KEY_ACTIVE_LOW = 1'b1
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic KEY_In,
  output logic KEY_OK,
  output logic KEY_Release,
  output logic KEY_Long,
  output logic KEY_Level
);

  logic raw_sync;
  logic s_key;

  state_t           state, state_next;
  logic [CNT_W-1:0] deb_cnt, deb_next;
  logic [CNT_W-1:0] hold_cnt, hold_next;
  logic             long_done, long_done_next;
  logic             ok_next, rel_next, long_next;

  // Reset to the released pin level so leaving reset never looks like a press.
  sync_2ff #(
    .RESET_VAL (KEY_ACTIVE_LOW)
  ) u_sync (
    .clk   (CLK),
    .rst_n (RSTn),
    .d     (KEY_In),
    .q     (raw_sync)
  );

  assign s_key = raw_sync ^ KEY_ACTIVE_LOW;

  // NOTE: every signal written here gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next     = state;
    deb_next       = deb_cnt;
    hold_next      = hold_cnt;
    long_done_next = long_done;
    ok_next        = 1'b0;
    rel_next       = 1'b0;
    long_next      = 1'b0;

    // Hold timer runs through release filtering, so a bounce does not restart it.
    if (is_down(state)) begin
      if (hold_cnt != T_LONG - 30'd1) begin
        hold_next = hold_cnt + 30'd1;
      end else if (!long_done) begin
        long_next      = 1'b1;
        long_done_next = 1'b1;
      end
    end

    case (state)
      IDLE: begin
        if (s_key) begin
          state_next = PRESS_FILT;
          deb_next   = '0;
        end
      end
      PRESS_FILT: begin
        if (!s_key) begin
          state_next = IDLE;
          deb_next   = '0;
        end else if (deb_cnt == T_DEBOUNCE - 30'd1) begin
          state_next     = PRESSED;
          ok_next        = 1'b1;
          hold_next      = '0;
          long_done_next = 1'b0;
        end else begin
          deb_next = deb_cnt + 30'd1;
        end
      end
      PRESSED: begin
        if (!s_key) begin
          state_next = REL_FILT;
          deb_next   = '0;
        end
      end
      REL_FILT: begin
        if (s_key) begin
          state_next = PRESSED;
        end else if (deb_cnt == T_DEBOUNCE - 30'd1) begin
          state_next = IDLE;
          rel_next   = 1'b1;
        end else begin
          deb_next = deb_cnt + 30'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state       <= IDLE;
      deb_cnt     <= '0;
      hold_cnt    <= '0;
      long_done   <= 1'b0;
      KEY_OK      <= 1'b0;
      KEY_Release <= 1'b0;
      KEY_Long    <= 1'b0;
      KEY_Level   <= 1'b0;
    end else begin
      state       <= state_next;
      deb_cnt     <= deb_next;
      hold_cnt    <= hold_next;
      long_done   <= long_done_next;
      KEY_OK      <= ok_next;
      KEY_Release <= rel_next;
      KEY_Long    <= long_next;
      KEY_Level   <= is_down(state_next);
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: stimulus queues expected pulse cycles
// and levels, a negedge monitor pops and compares them against the outputs.
module tb_key_debounce;

  logic CLK = 1'b0;
  logic RSTn;
  logic KEY_In;
  logic KEY_OK, KEY_Release, KEY_Long, KEY_Level;

  key_debounce #(
    .T_DEBOUNCE     (30'd4),
    .T_LONG         (30'd20),
    .KEY_ACTIVE_LOW (1'b1)
  ) dut (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .KEY_In      (KEY_In),
    .KEY_OK      (KEY_OK),
    .KEY_Release (KEY_Release),
    .KEY_Long    (KEY_Long),
    .KEY_Level   (KEY_Level)
  );

  always #5 CLK = ~CLK;

  // cyc equals N at the negedge following rising edge N.
  int cyc = 0;
  always @(posedge CLK) cyc++;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int   at;
    logic val;
  } lvl_t;

  int   q_ok[$];
  int   q_rel[$];
  int   q_long[$];
  lvl_t q_lvl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic push_lvl(input int at, input logic val);
    lvl_t e;
    e.at  = at;
    e.val = val;
    q_lvl.push_back(e);
  endtask

  // Monitor: every pulse must match the head of its queue; an expected pulse
  // that was never seen is reported once its cycle has passed.
  always @(negedge CLK) begin
    if (KEY_OK === 1'b1) begin
      if (q_ok.size() == 0) check("ok_unexpected", KEY_OK, 1'b0);
      else check("ok_cycle", cyc, q_ok.pop_front());
    end else if (q_ok.size() != 0 && q_ok[0] <= cyc) begin
      check("ok_missed", cyc, q_ok.pop_front() - 1);
    end

    if (KEY_Release === 1'b1) begin
      if (q_rel.size() == 0) check("rel_unexpected", KEY_Release, 1'b0);
      else check("rel_cycle", cyc, q_rel.pop_front());
    end else if (q_rel.size() != 0 && q_rel[0] <= cyc) begin
      check("rel_missed", cyc, q_rel.pop_front() - 1);
    end

    if (KEY_Long === 1'b1) begin
      if (q_long.size() == 0) check("long_unexpected", KEY_Long, 1'b0);
      else check("long_cycle", cyc, q_long.pop_front());
    end else if (q_long.size() != 0 && q_long[0] <= cyc) begin
      check("long_missed", cyc, q_long.pop_front() - 1);
    end

    while (q_lvl.size() != 0 && q_lvl[0].at <= cyc) begin
      if (q_lvl[0].at == cyc) check("level", KEY_Level, q_lvl[0].val);
      void'(q_lvl.pop_front());
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, m, g, p;

    // Reset held for three cycles with the key released.
    RSTn   = 1'b0;
    KEY_In = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      check("reset_outputs", {KEY_OK, KEY_Release, KEY_Long, KEY_Level}, 4'b0000);
    end
    RSTn = 1'b1;
    idle(8);
    check("idle_level", KEY_Level, 1'b0);

    // Press held 40 cycles: one KEY_OK 7 edges later, KEY_Long 20 edges after that.
    n = cyc;
    KEY_In = 1'b0;
    q_ok.push_back(n + 7);
    q_long.push_back(n + 27);
    push_lvl(n + 6, 1'b0);
    push_lvl(n + 7, 1'b1);
    push_lvl(n + 30, 1'b1);
    idle(40);

    // Release with a 2-cycle bounce back to pressed.
    m = cyc;
    KEY_In = 1'b1;
    idle(2);
    KEY_In = 1'b0;
    idle(2);
    KEY_In = 1'b1;
    q_rel.push_back(m + 11);
    push_lvl(m + 6, 1'b1);
    push_lvl(m + 10, 1'b1);
    push_lvl(m + 11, 1'b0);
    idle(15);

    // 3-cycle glitch: no event, level stays low.
    g = cyc;
    KEY_In = 1'b0;
    idle(3);
    KEY_In = 1'b1;
    push_lvl(g + 5, 1'b0);
    push_lvl(g + 8, 1'b0);
    idle(15);

    // Release timed so KEY_Long and KEY_Release land in the same cycle.
    n = cyc;
    KEY_In = 1'b0;
    q_ok.push_back(n + 7);
    idle(20);
    KEY_In = 1'b1;
    q_long.push_back(n + 27);
    q_rel.push_back(n + 27);
    push_lvl(n + 26, 1'b1);
    push_lvl(n + 27, 1'b0);
    idle(15);

    // Reset while PRESSED aborts silently.
    p = cyc;
    KEY_In = 1'b0;
    q_ok.push_back(p + 7);
    push_lvl(p + 7, 1'b1);
    idle(12);
    RSTn   = 1'b0;
    KEY_In = 1'b1;
    idle(1);
    check("abort_outputs", {KEY_OK, KEY_Release, KEY_Long, KEY_Level}, 4'b0000);
    check("abort_state", 32'(dut.state), 32'd0);
    RSTn = 1'b1;
    idle(20);
    check("post_abort_level", KEY_Level, 1'b0);

    check("ok_queue_drained", q_ok.size(), 0);
    check("rel_queue_drained", q_rel.size(), 0);
    check("long_queue_drained", q_long.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
